// File: rtl/fsm_msi_bus_snoop_controller.sv
// Snoop-side MSI controller: looks up the line addressed by a bus request,
// writes back MODIFIED data when required, then updates the line state.
module fsm_msi_bus_snoop_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int WB_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  snoop_valid,
    output logic                  snoop_ready,
    input  logic [1:0]            snoop_op,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  lookup_en,
    output logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic                  lookup_hit,
    input  logic [1:0]            lookup_state,
    output logic                  wb_req,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_ack,
    output logic                  state_wr_en,
    output logic [1:0]            state_wr_data,
    output logic                  snoop_done,
    output logic                  snoop_shared,
    output logic                  snoop_error
);
    localparam int CW = $clog2(WB_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(WB_TIMEOUT);

    localparam logic [1:0] ST_I = 2'b00, ST_M = 2'b01, ST_S = 2'b10;
    localparam logic [1:0] OP_INV = 2'b00, OP_WM = 2'b01, OP_RM = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DECIDE, S_WB, S_RESP} state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [1:0]      pend_data;
    logic            pend_sh;

    logic            dec_wb, dec_wr, dec_sh, dec_err;
    logic [1:0]      dec_data;

    assign cnt_inc = cnt + 1'b1;
    assign wb_addr = lookup_addr;

    // Action table applied to the lookup result in DECIDE.
    always_comb begin
        dec_wb   = 1'b0;
        dec_wr   = 1'b0;
        dec_err  = 1'b0;
        dec_data = ST_I;
        dec_sh   = lookup_hit && (lookup_state == ST_S || lookup_state == ST_M);
        if (op_q == 2'b11 || (lookup_hit && lookup_state == 2'b11)) begin
            dec_err = 1'b1;
        end else if (lookup_hit && lookup_state == ST_S) begin
            dec_wr = (op_q != OP_RM);
        end else if (lookup_hit && lookup_state == ST_M) begin
            case (op_q)
                OP_RM: begin
                    dec_wb   = 1'b1;
                    dec_data = ST_S;
                end
                OP_WM:   dec_wb  = 1'b1;
                default: dec_err = 1'b1;  // M alongside another sharer is impossible
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= OP_INV;
            cnt           <= '0;
            pend_data     <= ST_I;
            pend_sh       <= 1'b0;
            snoop_ready   <= 1'b1;
            lookup_en     <= 1'b0;
            lookup_addr   <= '0;
            wb_req        <= 1'b0;
            state_wr_en   <= 1'b0;
            state_wr_data <= 2'b00;
            snoop_done    <= 1'b0;
            snoop_shared  <= 1'b0;
            snoop_error   <= 1'b0;
        end else begin
            lookup_en     <= 1'b0;
            state_wr_en   <= 1'b0;
            state_wr_data <= 2'b00;
            snoop_done    <= 1'b0;
            snoop_shared  <= 1'b0;
            snoop_error   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (snoop_valid) begin
                        op_q        <= snoop_op;
                        lookup_addr <= snoop_addr;
                        snoop_ready <= 1'b0;
                        lookup_en   <= 1'b1;
                        state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= S_DECIDE;
                S_DECIDE: begin
                    if (dec_wb) begin
                        wb_req    <= 1'b1;
                        cnt       <= '0;
                        pend_data <= dec_data;
                        pend_sh   <= dec_sh;
                        state     <= S_WB;
                    end else begin
                        snoop_done    <= 1'b1;
                        state_wr_en   <= dec_wr;
                        state_wr_data <= dec_data;
                        snoop_shared  <= dec_sh;
                        snoop_error   <= dec_err;
                        state         <= S_RESP;
                    end
                end
                S_WB: begin
                    // An ack in the final allowed cycle still completes the write-back.
                    if (wb_ack) begin
                        wb_req        <= 1'b0;
                        snoop_done    <= 1'b1;
                        state_wr_en   <= 1'b1;
                        state_wr_data <= pend_data;
                        snoop_shared  <= pend_sh;
                        state         <= S_RESP;
                    end else if (cnt_inc == TO_VAL) begin
                        wb_req       <= 1'b0;
                        snoop_done   <= 1'b1;
                        snoop_shared <= pend_sh;
                        snoop_error  <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RESP: begin
                    snoop_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
